reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Holds NDOM reset domains in reset for HOLD_CYCLES clock edges after the
//   asynchronous board reset is removed. It then releases them one at a time,
//   lowest index first, with GAP_CYCLES edges between releases.
//
//   A synchronous software request restarts the whole sequence from any state.
//   The board reset (as_rst) asserts every domain reset immediately and
//   asynchronously. Its removal is synchronised by a 2-FF stage (rst_sync)
//   before the sequencer is allowed to advance.
//
// Optional feature (macro RESET_SEQ_TMR_EN):
//   When defined, the state, cnt, idx and dom_rst_n registers are triplicated.
//   - Every edge, all three copies load the majority-voted next value.
//   - Outputs are driven from the voted value.
//   - tmr_err pulses for one cycle whenever any copy disagrees with the vote.
//   When undefined, a single register copy is used and tmr_err is tied low.
//   Port list and cycle timing are identical in both builds.
//
// Parameters:
//   NDOM         number of reset domains (1..8)
//   HOLD_CYCLES  edges all domains stay asserted before the first release (>=1)
//   GAP_CYCLES   edges between consecutive domain releases (>=1)
//
// Ports:
//   clk          system clock, all outputs registered on its rising edge
//   as_rst       asynchronous active-low reset
//   sw_rst_req   synchronous active-high software reset request
//   dom_rst_n    per-domain active-low reset, bit 0 released first
//   busy         high while any domain is held in reset
//   done         high once every domain is released
//   tmr_err      one-cycle pulse on a voter disagreement (TMR build only)
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NDOM        = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            as_rst,
  input  logic            sw_rst_req,
  output logic [NDOM-1:0] dom_rst_n,
  output logic            busy,
  output logic            done,
  output logic            tmr_err
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NDOM + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDOM - 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // ---------------------------------------------------------------------------
  // Reset release synchroniser: as_rst asserts asynchronously, deasserts
  // through two flops so the sequencer never sees a metastable release.
  // ---------------------------------------------------------------------------
  logic sync_ff1;
  logic rst_sync;

  always_ff @(posedge clk or negedge as_rst) begin
    if (!as_rst) begin
      sync_ff1 <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync_ff1 <= 1'b1;
      rst_sync <= sync_ff1;
    end
  end

  // Current (voted, in the TMR build) register values and their next values.
  logic [1:0]       state_v;
  logic [CNT_W-1:0] cnt_v;
  logic [IDX_W-1:0] idx_v;
  logic [NDOM-1:0]  dom_v;

  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [NDOM-1:0]  dom_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic             busy_q;
  logic             done_q;
  logic             tmr_err_q;

  // ---------------------------------------------------------------------------
  // State register process
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_TMR_EN
  logic [1:0]       state_a, state_b, state_c;
  logic [CNT_W-1:0] cnt_a,   cnt_b,   cnt_c;
  logic [IDX_W-1:0] idx_a,   idx_b,   idx_c;
  logic [NDOM-1:0]  dom_a,   dom_b,   dom_c;
  logic             vote_mismatch;

  assign state_v = (state_a & state_b) | (state_a & state_c) | (state_b & state_c);
  assign cnt_v   = (cnt_a & cnt_b)     | (cnt_a & cnt_c)     | (cnt_b & cnt_c);
  assign idx_v   = (idx_a & idx_b)     | (idx_a & idx_c)     | (idx_b & idx_c);
  assign dom_v   = (dom_a & dom_b)     | (dom_a & dom_c)     | (dom_b & dom_c);

  assign vote_mismatch = (state_a != state_v) | (state_b != state_v) | (state_c != state_v) |
                         (cnt_a   != cnt_v)   | (cnt_b   != cnt_v)   | (cnt_c   != cnt_v)   |
                         (idx_a   != idx_v)   | (idx_b   != idx_v)   | (idx_c   != idx_v)   |
                         (dom_a   != dom_v)   | (dom_b   != dom_v)   | (dom_c   != dom_v);

  always_ff @(posedge clk or negedge as_rst) begin
    if (!as_rst) begin
      state_a   <= ST_ASSERT;
      state_b   <= ST_ASSERT;
      state_c   <= ST_ASSERT;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_c     <= '0;
      idx_a     <= '0;
      idx_b     <= '0;
      idx_c     <= '0;
      dom_a     <= '0;
      dom_b     <= '0;
      dom_c     <= '0;
      tmr_err_q <= 1'b0;
    end else begin
      // All copies reload from the voted next value, scrubbing a single upset.
      state_a   <= state_nxt;
      state_b   <= state_nxt;
      state_c   <= state_nxt;
      cnt_a     <= cnt_nxt;
      cnt_b     <= cnt_nxt;
      cnt_c     <= cnt_nxt;
      idx_a     <= idx_nxt;
      idx_b     <= idx_nxt;
      idx_c     <= idx_nxt;
      dom_a     <= dom_nxt;
      dom_b     <= dom_nxt;
      dom_c     <= dom_nxt;
      tmr_err_q <= vote_mismatch;
    end
  end
`else
  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [NDOM-1:0]  dom_q;

  assign state_v   = state_q;
  assign cnt_v     = cnt_q;
  assign idx_v     = idx_q;
  assign dom_v     = dom_q;
  assign tmr_err_q = 1'b0;

  always_ff @(posedge clk or negedge as_rst) begin
    if (!as_rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      dom_q   <= dom_nxt;
    end
  end
`endif

  // busy/done are pure functions of the sequence position, so they are not
  // triplicated; they are registered alongside so they change on the same edge.
  always_ff @(posedge clk or negedge as_rst) begin
    if (!as_rst) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state process
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_v;
    cnt_nxt   = cnt_v;
    idx_nxt   = idx_v;
    dom_nxt   = dom_v;
    busy_nxt  = busy_q;
    done_nxt  = done_q;

    if (sw_rst_req) begin
      // Software request wins over everything, and keeps cnt at 0 while held.
      state_nxt = ST_ASSERT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dom_nxt   = '0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
    end else if (rst_sync) begin
      case (state_v)
        ST_ASSERT: begin
          dom_nxt  = '0;
          busy_nxt = 1'b1;
          done_nxt = 1'b0;
          if (cnt_v == HOLD_LAST) begin
            dom_nxt[0] = 1'b1;
            idx_nxt    = IDX_W'(1);
            cnt_nxt    = '0;
            if (NDOM == 1) begin
              state_nxt = ST_RUN;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end else begin
            cnt_nxt = cnt_v + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_v == GAP_LAST) begin
            // A loop compare avoids indexing dom_nxt with a wider idx.
            for (int i = 0; i < NDOM; i++) begin
              if (idx_v == IDX_W'(i)) begin
                dom_nxt[i] = 1'b1;
              end
            end
            idx_nxt = idx_v + IDX_W'(1);
            cnt_nxt = '0;
            if (idx_v == IDX_LAST) begin
              state_nxt = ST_RUN;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_v + CNT_W'(1);
          end
        end

        ST_RUN: begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end

        default: begin
          // Unused encoding: restart a clean sequence.
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output process
  // ---------------------------------------------------------------------------
  always_comb begin
    dom_rst_n = dom_v;
    busy      = busy_q;
    done      = done_q;
    tmr_err   = tmr_err_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer.
//   dut  : default parameters (NDOM=3, HOLD_CYCLES=16, GAP_CYCLES=4)
//   dut1 : NDOM=1, HOLD_CYCLES=1, GAP_CYCLES=1
// Both instances share clock and reset inputs. Edge numbers below count rising
// clock edges after the relevant stimulus change.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       as_rst;
  logic       sw_rst_req;

  logic [2:0] dom_rst_n;
  logic       busy;
  logic       done;
  logic       tmr_err;

  logic [0:0] dom1_rst_n;
  logic       busy1;
  logic       done1;
  logic       tmr_err1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NDOM        (3),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .as_rst     (as_rst),
    .sw_rst_req (sw_rst_req),
    .dom_rst_n  (dom_rst_n),
    .busy       (busy),
    .done       (done),
    .tmr_err    (tmr_err)
  );

  reset_sequencer #(
    .NDOM        (1),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1)
  ) dut1 (
    .clk        (clk),
    .as_rst     (as_rst),
    .sw_rst_req (sw_rst_req),
    .dom_rst_n  (dom1_rst_n),
    .busy       (busy1),
    .done       (done1),
    .tmr_err    (tmr_err1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived release schedule for the default instance.
  // k counts edges from the start of the sequencer's count (edge 0 = reset
  // point): bit0 at k=16, bit1 at k=20, bit2 at k=24.
  function automatic logic [7:0] sched(input int k);
    if (k >= 24) return 8'h7;
    if (k >= 20) return 8'h3;
    if (k >= 16) return 8'h1;
    return 8'h0;
  endfunction

  initial begin
    as_rst     = 1'b0;
    sw_rst_req = 1'b0;

    // Power-on reset state.
    repeat (5) tick();
    check("rst_dom",   8'(dom_rst_n),  8'h0);
    check("rst_busy",  8'(busy),       8'h1);
    check("rst_done",  8'(done),       8'h0);
    check("rst_tmr",   8'(tmr_err),    8'h0);
    check("rst_dom1",  8'(dom1_rst_n), 8'h0);
    check("rst_done1", 8'(done1),      8'h0);

    // Power-up release: the two synchroniser edges are added to the schedule.
    @(negedge clk);
    as_rst = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check("pwr_dom",  8'(dom_rst_n), sched(e - 2));
      check("pwr_busy", 8'(busy),      (e >= 26) ? 8'h0 : 8'h1);
      check("pwr_done", 8'(done),      (e >= 26) ? 8'h1 : 8'h0);
      check("pwr_dom1",  8'(dom1_rst_n), (e >= 3) ? 8'h1 : 8'h0);
      check("pwr_done1", 8'(done1),      (e >= 3) ? 8'h1 : 8'h0);
      check("pwr_busy1", 8'(busy1),      (e >= 3) ? 8'h0 : 8'h1);
    end

    // Software reset pulse while in RUN.
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("swp_dom_E",   8'(dom_rst_n),  8'h0);
    check("swp_busy_E",  8'(busy),       8'h1);
    check("swp_done_E",  8'(done),       8'h0);
    check("swp_dom1_E",  8'(dom1_rst_n), 8'h0);
    check("swp_done1_E", 8'(done1),      8'h0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("swp_dom",  8'(dom_rst_n), sched(k));
      check("swp_done", 8'(done), (k >= 24) ? 8'h1 : 8'h0);
      check("swp_busy", 8'(busy), (k >= 24) ? 8'h0 : 8'h1);
      if (k == 1) begin
        check("swp_dom1",  8'(dom1_rst_n), 8'h1);
        check("swp_done1", 8'(done1),      8'h1);
      end
    end

    // Software request held high for 10 edges: stays in ASSERT.
    @(negedge clk);
    sw_rst_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("hold_dom",  8'(dom_rst_n), 8'h0);
      check("hold_busy", 8'(busy),      8'h1);
    end
    sw_rst_req = 1'b0;
    // Count restarts from the last edge the request was sampled high.
    for (int k = 1; k <= 21; k++) begin
      tick();
      check("hold_rel_dom", 8'(dom_rst_n), sched(k));
    end

    // Pulse two edges after bit1 was released.
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("mid_dom_E",  8'(dom_rst_n), 8'h0);
    check("mid_busy_E", 8'(busy),      8'h1);
    check("mid_done_E", 8'(done),      8'h0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("mid_dom",  8'(dom_rst_n), sched(k));
      check("mid_done", 8'(done), (k >= 24) ? 8'h1 : 8'h0);
    end

    // Asynchronous reset mid-RELEASE (between bit0 and bit1 release).
    @(negedge clk);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("pre_async_dom", 8'(dom_rst_n), sched(k));
    end
    #2;
    as_rst = 1'b0;
    #1;
    check("async_dom",   8'(dom_rst_n),  8'h0);
    check("async_busy",  8'(busy),       8'h1);
    check("async_done",  8'(done),       8'h0);
    check("async_tmr",   8'(tmr_err),    8'h0);
    check("async_dom1",  8'(dom1_rst_n), 8'h0);
    repeat (3) tick();
    check("async_hold_dom", 8'(dom_rst_n), 8'h0);
    @(negedge clk);
    as_rst = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      check("rerun_dom",  8'(dom_rst_n), sched(e - 2));
      check("rerun_done", 8'(done), (e >= 26) ? 8'h1 : 8'h0);
    end
    check("rerun_tmr", 8'(tmr_err), 8'h0);

`ifdef RESET_SEQ_TMR_EN
    // Upset one cnt copy in ASSERT and check the vote masks it.
    as_rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    as_rst = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    @(negedge clk);
    force dut.cnt_b = 5'd31;
    #4;
    release dut.cnt_b;
    tick();
    check("tmr_pulse", 8'(tmr_err), 8'h1);
    tick();
    check("tmr_clear", 8'(tmr_err), 8'h0);
    for (int e = 8; e <= 18; e++) begin
      tick();
      check("tmr_dom", 8'(dom_rst_n), sched(e - 2));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
